// File: rtl/pcie_app_msg_adapter.sv
// pcie_app_msg_adapter: per-slot adapter between the PCI-E virtualization
// layer and one application.
//
// Inbound beats (pkt_in_*) are reassembled into whole messages (msg_*).
// Beats beyond MAX_BEATS are dropped, and that drop is flagged on msg_overflow.
// Application responses (resp_*) are serialized into outbound beats
// (pkt_out_*). Each beat is consumed by the layer on grant_in.
//
// Ports:
//   clock, reset_n        single clock, async active-low reset
//   pkt_in_*, full_out    inbound beat, back-pressure to the layer
//   pkt_out_*, grant_in   outbound beat, consumed on grant_in
//   msg_*                 reassembled message, valid/ready handshake
//   resp_*                response message, valid/ready handshake
module pcie_app_msg_adapter #(
    parameter int DATA_W    = 128,
    parameter int MAX_BEATS = 4,
    parameter int SLOT_W    = 8,
    parameter int PAD_W     = 3
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            pkt_in_valid,
    input  logic [DATA_W-1:0]               pkt_in_data,
    input  logic [SLOT_W-1:0]               pkt_in_slot,
    input  logic [PAD_W-1:0]                pkt_in_pad,
    input  logic                            pkt_in_last,
    output logic                            full_out,
    output logic                            pkt_out_valid,
    output logic [DATA_W-1:0]               pkt_out_data,
    output logic [SLOT_W-1:0]               pkt_out_slot,
    output logic [PAD_W-1:0]                pkt_out_pad,
    output logic                            pkt_out_last,
    input  logic                            grant_in,
    output logic                            msg_valid,
    input  logic                            msg_ready,
    output logic [MAX_BEATS*DATA_W-1:0]     msg_data,
    output logic [$clog2(MAX_BEATS+1)-1:0]  msg_beats,
    output logic [SLOT_W-1:0]               msg_slot,
    output logic                            msg_overflow,
    input  logic                            resp_valid,
    output logic                            resp_ready,
    input  logic [MAX_BEATS*DATA_W-1:0]     resp_data,
    input  logic [$clog2(MAX_BEATS+1)-1:0]  resp_beats,
    input  logic [SLOT_W-1:0]               resp_slot
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {COLLECT, DISCARD, DELIVER} rx_state_t;
    typedef enum logic {IDLE, SEND} tx_state_t;

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    rx_state_t        rx_state;
    rx_state_t        rx_next;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             at_top;
    logic             pad_unused;

    assign pad_unused = ^pkt_in_pad;
    assign full_out   = (rx_state == DELIVER);
    assign msg_valid  = (rx_state == DELIVER);
    assign accept     = pkt_in_valid && !full_out;
    assign at_top     = (count == CNT_W'(MAX_BEATS - 1));

    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            COLLECT: begin
                if (accept) begin
                    if (pkt_in_last)
                        rx_next = DELIVER;
                    else if (at_top)
                        rx_next = DISCARD;
                end
            end
            DISCARD: begin
                if (accept && pkt_in_last)
                    rx_next = DELIVER;
            end
            DELIVER: begin
                if (msg_ready)
                    rx_next = COLLECT;
            end
            default: rx_next = COLLECT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            rx_state <= COLLECT;
        else
            rx_state <= rx_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count        <= '0;
            msg_data     <= '0;
            msg_beats    <= '0;
            msg_slot     <= '0;
            msg_overflow <= 1'b0;
        end else if (rx_state == COLLECT && accept) begin
            for (int i = 0; i < MAX_BEATS; i++) begin
                if (count == CNT_W'(i))
                    msg_data[i*DATA_W +: DATA_W] <= pkt_in_data;
            end
            if (count == '0)
                msg_slot <= pkt_in_slot;
            count <= count + 1'b1;
            if (pkt_in_last) begin
                msg_beats    <= count + 1'b1;
                msg_overflow <= 1'b0;
            end else if (at_top) begin
                msg_beats    <= CNT_W'(MAX_BEATS);
                msg_overflow <= 1'b1;
            end
        end else if (rx_state == DELIVER && msg_ready) begin
            count <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    tx_state_t                   tx_state;
    tx_state_t                   tx_next;
    logic [CNT_W-1:0]            idx;
    logic [CNT_W-1:0]            tx_beats;
    logic [CNT_W-1:0]            clamped;
    logic [MAX_BEATS*DATA_W-1:0] tx_data;
    logic [SLOT_W-1:0]           tx_slot;
    logic [DATA_W-1:0]           tx_lane;
    logic                        tx_last;
    logic                        take;
    logic                        send;

    assign take    = resp_valid && resp_ready;
    assign send    = (tx_state == SEND);
    assign tx_last = (idx == tx_beats - 1'b1);

    always_comb begin
        clamped = resp_beats;
        if (resp_beats == '0)
            clamped = CNT_W'(1);
        else if (resp_beats > CNT_W'(MAX_BEATS))
            clamped = CNT_W'(MAX_BEATS);
    end

    always_comb begin
        tx_next = tx_state;
        unique case (tx_state)
            IDLE:    if (take) tx_next = SEND;
            SEND:    if (grant_in && tx_last) tx_next = IDLE;
            default: tx_next = IDLE;
        endcase
    end

    // resp_ready is its own flop so it stays low during reset and only
    // rises on the first edge after release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state   <= IDLE;
            resp_ready <= 1'b0;
        end else begin
            tx_state   <= tx_next;
            resp_ready <= (tx_next == IDLE);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx      <= '0;
            tx_beats <= '0;
            tx_data  <= '0;
            tx_slot  <= '0;
        end else if (take) begin
            idx      <= '0;
            tx_beats <= clamped;
            tx_data  <= resp_data;
            tx_slot  <= resp_slot;
        end else if (send && grant_in && !tx_last) begin
            idx <= idx + 1'b1;
        end
    end

    always_comb begin
        tx_lane = '0;
        for (int i = 0; i < MAX_BEATS; i++) begin
            if (idx == CNT_W'(i))
                tx_lane = tx_data[i*DATA_W +: DATA_W];
        end
    end

    // Outbound fields read as zero whenever no beat is offered.
    assign pkt_out_valid = send;
    assign pkt_out_data  = send ? tx_lane : '0;
    assign pkt_out_slot  = send ? tx_slot : '0;
    assign pkt_out_pad   = '0;
    assign pkt_out_last  = send && tx_last;

endmodule
